// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared definitions for the APB command master slice.
//   - apb_state_t : 2-bit FSM encoding (IDLE, SETUP, ACCESS, RESP)
//   - DEFAULT_ADDR_WIDTH / DEFAULT_DATA_WIDTH : default bus widths
//   - TDR_ADDR / TCR_ADDR : timer_counter_8bit register addresses
//   - cnt_width() : width of the ACCESS wait counter for a given limit
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [2:0] TDR_ADDR = 3'b010;
  localparam logic [2:0] TCR_ADDR = 3'b011;

  // A limit of 0 means "no timeout"; keep a 1-bit counter so the
  // hardware still elaborates with a legal width.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if
//   Bundles the command channel, the response channel and the APB bus of
//   the command master.
//   Ports (signals):
//     cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command in
//     rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout : response out
//     psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB
//   Modports:
//     master : the command master (drives APB controls and responses)
//     slave  : the environment (drives commands and APB slave replies)
interface apb_cmd_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt
//   Counts ACCESS cycles spent waiting for pready.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     clear    : load 1, i.e. "this is the first ACCESS cycle"
//     enable   : advance by one (saturating, never wraps)
//     limit    : abort threshold, 0 disables expiry
//     expired  : current cycle is the limit cycle (or beyond)
module apb_timeout_cnt #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Clear happens on the edge entering ACCESS, so the count already reads 1
  // during the first ACCESS cycle and equals N during the N-th one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= WIDTH'(1);
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = (limit != '0) && (count >= limit);

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   APB initiator: accepts one command at a time on a valid/ready channel,
//   runs it as an APB SETUP/ACCESS transfer and returns the result on a
//   response channel that is held until consumed.
//   Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT (ACCESS cycles before abort,
//   0 = wait forever).
//   Ports:
//     pclk   : clock, rising edge
//     preset : asynchronous active-high reset
//     bus    : apb_cmd_master_if.master (command, response and APB signals)
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic             pclk,
  input  logic             preset,
  apb_cmd_master_if.master bus
);

  localparam int                   CNT_WIDTH = cnt_width(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

  apb_state_t state, state_next;

  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  pwrite_q,      pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  apb_timeout_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_timeout_cnt (
    .clk     (pclk),
    .rst     (preset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .limit   (CNT_LIMIT),
    .expired (cnt_expired)
  );

  // Next state and next register values. Every output holds by default so
  // paddr/pwrite/pwdata keep their last values while the bus is idle and
  // the response payload stays stable while it waits in RESP.
  always_comb begin
    state_next    = state;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_clear     = 1'b0;
    cnt_enable    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_next = ST_SETUP;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = bus.cmd_write;
          paddr_d    = bus.cmd_addr;
          pwdata_d   = bus.cmd_write ? bus.cmd_wdata : '0;
        end
      end

      ST_SETUP: begin
        state_next = ST_ACCESS;
        penable_d  = 1'b1;
        cnt_clear  = 1'b1;
      end

      // pready is checked before the limit so a slave answering on the
      // limit cycle still completes normally.
      ST_ACCESS: begin
        if (bus.pready) begin
          state_next    = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
        end else if (cnt_expired) begin
          state_next    = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_next  = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and all bus/response outputs are registered; reset clears them
  // immediately, dropping any transfer or pending response.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state         <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state         <= state_next;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Ready is only offered from IDLE, and never while reset is held.
  assign bus.cmd_ready   = (state == ST_IDLE) && !preset;

  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master
//   Drives apb_cmd_master with directed and random commands while playing
//   the APB slave and the response consumer. A transaction-level model
//   derives, for every cycle of a command, what the outputs must be from
//   its wait count and response delay; a negedge process compares the DUT
//   against it, and literal expectations pin the directed scenarios.
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int AW      = 3;
  localparam int DW      = 8;
  localparam int TIMEOUT = 4;

  logic pclk   = 1'b0;
  logic preset = 1'b1;

  apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_cmd_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          write;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    int          waits;
    logic [7:0]  rdata;
    bit          slverr;
    int          rsp_delay;
  } txn_t;

  typedef struct {
    logic       cmd_ready;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
  } exp_t;

  int   checks;
  int   passes;
  exp_t exp_now;
  bit   exp_on;

  logic       m_write;
  logic [2:0] m_addr;
  logic [7:0] m_wdata;

  int         psel_count;
  int         penable_count;
  int         rsp_count;
  logic [7:0] seen_rdata;
  logic       seen_err;
  logic       seen_timeout;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                  name, actual, expected, $time);
  endtask

  function automatic txn_t make_txn(input bit write, input logic [2:0] addr,
                                    input logic [7:0] wdata, input int waits,
                                    input logic [7:0] rdata, input bit slverr,
                                    input int rsp_delay);
    txn_t t;
    t.write = write; t.addr = addr; t.wdata = wdata; t.waits = waits;
    t.rdata = rdata; t.slverr = slverr; t.rsp_delay = rsp_delay;
    return t;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.cmd_ready = 1'b1; e.psel = 1'b0; e.penable = 1'b0;
    e.pwrite = m_write; e.paddr = m_addr; e.pwdata = m_wdata;
    e.rsp_valid = 1'b0; e.rsp_rdata = '0; e.rsp_err = 1'b0; e.rsp_timeout = 1'b0;
    return e;
  endfunction

  task automatic clear_counts();
    psel_count = 0; penable_count = 0; rsp_count = 0;
    seen_rdata = 'x; seen_err = 1'bx; seen_timeout = 1'bx;
  endtask

  task automatic random_inputs();
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = 3'($urandom);
    bus.cmd_wdata = 8'($urandom);
    bus.prdata    = 8'($urandom);
    bus.pready    = 1'($urandom_range(0, 1));
    bus.pslverr   = 1'($urandom_range(0, 1));
    bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      random_inputs();
      bus.cmd_valid = 1'b0;
      exp_now = idle_exp();
      exp_on  = 1'b1;
    end
  endtask

  // One command, cycle k counted from the acceptance cycle. Timeline:
  // k=0 accept, k=1 SETUP, then A ACCESS cycles, then R response cycles.
  task automatic apply_stimulus(input txn_t t);
    exp_t e;
    bit   to;
    int   a, r, total;
    to    = (TIMEOUT != 0) && (t.waits + 1 > TIMEOUT);
    a     = to ? TIMEOUT : t.waits + 1;
    r     = t.rsp_delay + 1;
    total = 2 + a + r;
    for (int k = 0; k < total; k++) begin
      @(posedge pclk); #1;
      random_inputs();
      if (k == 0) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = t.write;
        bus.cmd_addr  = t.addr;
        bus.cmd_wdata = t.wdata;
      end
      if (k >= 2 && k < 2 + a) begin
        bus.pready = ((k - 1) == t.waits + 1);
        if (bus.pready) begin
          bus.prdata  = t.rdata;
          bus.pslverr = t.slverr;
        end
      end
      if (k >= 2 + a) bus.rsp_ready = ((k - 2 - a) == t.rsp_delay);
      if (k == 1) begin
        m_write = t.write;
        m_addr  = t.addr;
        m_wdata = t.write ? t.wdata : 8'h00;
      end
      e = idle_exp();
      e.cmd_ready = (k == 0);
      e.psel      = (k >= 1) && (k < 2 + a);
      e.penable   = (k >= 2) && (k < 2 + a);
      e.rsp_valid = (k >= 2 + a);
      if (e.rsp_valid) begin
        e.rsp_rdata   = (to || t.write) ? 8'h00 : t.rdata;
        e.rsp_err     = to || t.slverr;
        e.rsp_timeout = to;
      end
      exp_now = e;
      exp_on  = 1'b1;
    end
  endtask

  // Accept a read, hold pready low and pulse reset in the second ACCESS cycle.
  task automatic reset_mid_access();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      @(posedge pclk); #1;
      bus.cmd_valid = (k == 0); bus.cmd_write = 1'b0; bus.cmd_addr = TDR_ADDR;
      bus.cmd_wdata = 8'h00; bus.pready = 1'b0; bus.pslverr = 1'b0;
      bus.prdata = 8'h00; bus.rsp_ready = 1'b1;
      if (k == 1) begin m_write = 1'b0; m_addr = TDR_ADDR; m_wdata = 8'h00; end
      e = idle_exp();
      e.cmd_ready = (k == 0);
      e.psel      = (k >= 1);
      e.penable   = (k >= 2);
      exp_now = e;
      exp_on  = 1'b1;
    end
    @(negedge pclk); #1;
    exp_on = 1'b0;
    preset = 1'b1;
    #1;
    check_output("rst_mid_psel",      32'(bus.psel),      32'd0);
    check_output("rst_mid_penable",   32'(bus.penable),   32'd0);
    check_output("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_output("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("rst_mid_paddr",     32'(bus.paddr),     32'd0);
    m_write = 1'b0; m_addr = '0; m_wdata = '0;
    @(posedge pclk); #1;
    preset = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model while it is active.
  always @(negedge pclk) begin
    if (exp_on) begin
      check_output("cmd_ready", 32'(bus.cmd_ready), 32'(exp_now.cmd_ready));
      check_output("psel",      32'(bus.psel),      32'(exp_now.psel));
      check_output("penable",   32'(bus.penable),   32'(exp_now.penable));
      check_output("pwrite",    32'(bus.pwrite),    32'(exp_now.pwrite));
      check_output("paddr",     32'(bus.paddr),     32'(exp_now.paddr));
      check_output("pwdata",    32'(bus.pwdata),    32'(exp_now.pwdata));
      check_output("rsp_valid", 32'(bus.rsp_valid), 32'(exp_now.rsp_valid));
      if (exp_now.rsp_valid) begin
        check_output("rsp_rdata",   32'(bus.rsp_rdata),   32'(exp_now.rsp_rdata));
        check_output("rsp_err",     32'(bus.rsp_err),     32'(exp_now.rsp_err));
        check_output("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_now.rsp_timeout));
      end
      if (bus.psel === 1'b1)    psel_count++;
      if (bus.penable === 1'b1) penable_count++;
      if (bus.rsp_valid === 1'b1) begin
        rsp_count++;
        seen_rdata   = bus.rsp_rdata;
        seen_err     = bus.rsp_err;
        seen_timeout = bus.rsp_timeout;
      end
    end
  end

  initial begin
    checks = 0; passes = 0; exp_on = 1'b0;
    m_write = 1'b0; m_addr = '0; m_wdata = '0;
    clear_counts();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.prdata = '0; bus.pready = 1'b0;
    bus.pslverr = 1'b0; bus.rsp_ready = 1'b0;
    preset = 1'b1;

    repeat (2) @(posedge pclk);
    #1;
    check_output("reset_cmd_ready",   32'(bus.cmd_ready),   32'd0);
    check_output("reset_psel",        32'(bus.psel),        32'd0);
    check_output("reset_penable",     32'(bus.penable),     32'd0);
    check_output("reset_pwrite",      32'(bus.pwrite),      32'd0);
    check_output("reset_paddr",       32'(bus.paddr),       32'd0);
    check_output("reset_pwdata",      32'(bus.pwdata),      32'd0);
    check_output("reset_rsp_valid",   32'(bus.rsp_valid),   32'd0);
    check_output("reset_rsp_rdata",   32'(bus.rsp_rdata),   32'd0);
    check_output("reset_rsp_err",     32'(bus.rsp_err),     32'd0);
    check_output("reset_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    preset = 1'b0;
    idle_cycles(2);

    $display("[TB] zero-wait write");
    clear_counts();
    apply_stimulus(make_txn(1'b1, TDR_ADDR, 8'h5A, 0, 8'h00, 1'b0, 0));
    idle_cycles(1);
    check_output("t1_psel_cycles",    32'(psel_count),    32'd2);
    check_output("t1_penable_cycles", 32'(penable_count), 32'd1);
    check_output("t1_rsp_cycles",     32'(rsp_count),     32'd1);
    check_output("t1_err",            32'(seen_err),      32'd0);
    check_output("t1_timeout",        32'(seen_timeout),  32'd0);

    $display("[TB] read with 3 wait states");
    clear_counts();
    apply_stimulus(make_txn(1'b0, TCR_ADDR, 8'hFF, 3, 8'hA3, 1'b0, 0));
    idle_cycles(1);
    check_output("t2_psel_cycles",    32'(psel_count),    32'd5);
    check_output("t2_penable_cycles", 32'(penable_count), 32'd4);
    check_output("t2_rdata",          32'(seen_rdata),    32'hA3);
    check_output("t2_timeout",        32'(seen_timeout),  32'd0);

    $display("[TB] slave error then normal read");
    clear_counts();
    apply_stimulus(make_txn(1'b1, TCR_ADDR, 8'h11, 0, 8'h77, 1'b1, 0));
    idle_cycles(1);
    check_output("t3_err",     32'(seen_err),     32'd1);
    check_output("t3_timeout", 32'(seen_timeout), 32'd0);
    check_output("t3_rdata",   32'(seen_rdata),   32'd0);
    clear_counts();
    apply_stimulus(make_txn(1'b0, TDR_ADDR, 8'h00, 1, 8'h3C, 1'b0, 0));
    idle_cycles(1);
    check_output("t3b_err",   32'(seen_err),   32'd0);
    check_output("t3b_rdata", 32'(seen_rdata), 32'h3C);

    $display("[TB] timeout with pready stuck low");
    clear_counts();
    apply_stimulus(make_txn(1'b0, TDR_ADDR, 8'h00, 50, 8'hEE, 1'b0, 0));
    idle_cycles(1);
    check_output("t4_penable_cycles", 32'(penable_count), 32'd4);
    check_output("t4_err",            32'(seen_err),      32'd1);
    check_output("t4_timeout",        32'(seen_timeout),  32'd1);
    check_output("t4_rdata",          32'(seen_rdata),    32'd0);

    $display("[TB] response back-pressure");
    clear_counts();
    apply_stimulus(make_txn(1'b1, 3'd5, 8'hC4, 0, 8'h00, 1'b0, 5));
    idle_cycles(1);
    check_output("t5_rsp_cycles", 32'(rsp_count), 32'd6);

    $display("[TB] reset during ACCESS");
    reset_mid_access();
    idle_cycles(2);
    clear_counts();
    apply_stimulus(make_txn(1'b0, TCR_ADDR, 8'h00, 0, 8'h96, 1'b0, 0));
    idle_cycles(1);
    check_output("t6_rsp_cycles", 32'(rsp_count),  32'd1);
    check_output("t6_rdata",      32'(seen_rdata), 32'h96);

    $display("[TB] random commands");
    for (int n = 0; n < 40; n++) begin
      apply_stimulus(make_txn(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                              int'($urandom_range(0, 6)), 8'($urandom),
                              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3))));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end
    idle_cycles(2);
    exp_on = 1'b0;

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
